pp_bank_scheduler: RTL and testbench

PP_BANK_SCHEDULER -- requirements
Module: pp_bank_scheduler

---
 rtl/pp_bank_scheduler.sv | 133 +++++++++++++
 tb/tb_pp_bank_scheduler.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/pp_bank_scheduler.sv
// pp_bank_scheduler: ping-pong bank scheduler between a streaming writer and
// a multi-pass matmul reader. Each of two banks cycles EMPTY -> FILL -> FULL
// -> READ -> EMPTY. The writer fills wr_bank with DEPTH beats, and then the
// writer moves to the other bank. The reader claims a FULL rd_bank and runs
// RD_PASSES passes over it. Each pass ends on a rising edge of acc_done. After
// the last pass the reader releases the bank.
//
// Parameters:
//   ADDR_WIDTH  width of the per-bank write address
//   DEPTH       number of words in one bank fill (2 .. 2**ADDR_WIDTH)
//   RD_PASSES   number of matmul passes read from a bank before it is released
//
// Ports:
//   clk, rst_n     clock (rising edge) and asynchronous active-low reset
//   in_valid       producer offers one write beat
//   in_ready       the current write bank can accept a beat
//   wr_en          a beat is accepted this cycle
//   wr_bank        bank that receives writes
//   wr_addr        address of the current beat in wr_bank
//   acc_done       accumulator-done level; a rising edge ends one pass
//   rd_bank        bank owned by the reader
//   rd_active      the reader is draining rd_bank
//   enable_matmul  one-cycle pulse that starts a pass
//   bank_full      bit b is set while bank b holds complete data (unread or being read)
//   stall_cnt      only with PP_SCHED_PERF_EN defined: saturating 16-bit count
//                  of cycles with in_valid high and in_ready low
module pp_bank_scheduler #(
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 8,
  parameter int RD_PASSES  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  wr_en,
  output logic                  wr_bank,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic                  acc_done,
  output logic                  rd_bank,
  output logic                  rd_active,
  output logic                  enable_matmul,
`ifdef PP_SCHED_PERF_EN
  output logic [15:0]           stall_cnt,
`endif
  output logic [1:0]            bank_full
);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;
  localparam logic [1:0] S_READ  = 2'd3;

  localparam int PW = (RD_PASSES > 1) ? $clog2(RD_PASSES) : 1;

  logic [1:0]    state [2];
  logic [PW-1:0] pass_cnt;
  logic          acc_d;
  logic          acc_rise;
  logic          last_beat;
  logic          last_pass;

  assign in_ready  = (state[wr_bank] == S_EMPTY) || (state[wr_bank] == S_FILL);
  assign wr_en     = in_valid & in_ready;
  assign acc_rise  = acc_done & ~acc_d;
  assign last_beat = (wr_addr == ADDR_WIDTH'(DEPTH - 1));
  assign last_pass = (pass_cnt == PW'(RD_PASSES - 1));

  // A bank counts as full from the cycle after its last beat until the cycle after it is released.
  assign bank_full[0] = (state[0] == S_FULL) || (state[0] == S_READ);
  assign bank_full[1] = (state[1] == S_FULL) || (state[1] == S_READ);

  // The writer only touches state[wr_bank] when that bank is EMPTY or FILL.
  // The reader only touches state[rd_bank] when that bank is FULL or READ.
  // So the two updates can never target the same bank in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state[0]      <= S_EMPTY;
      state[1]      <= S_EMPTY;
      wr_bank       <= 1'b0;
      wr_addr       <= '0;
      rd_bank       <= 1'b0;
      rd_active     <= 1'b0;
      enable_matmul <= 1'b0;
      pass_cnt      <= '0;
      acc_d         <= 1'b0;
    end else begin
      acc_d         <= acc_done;
      enable_matmul <= 1'b0;

      if (wr_en) begin
        if (last_beat) begin
          state[wr_bank] <= S_FULL;
          wr_addr        <= '0;
          wr_bank        <= ~wr_bank;
        end else begin
          state[wr_bank] <= S_FILL;
          wr_addr        <= wr_addr + 1'b1;
        end
      end

      if (!rd_active) begin
        if (state[rd_bank] == S_FULL) begin
          state[rd_bank] <= S_READ;
          rd_active      <= 1'b1;
          enable_matmul  <= 1'b1;
          pass_cnt       <= '0;
        end
      end else if (acc_rise) begin
        if (last_pass) begin
          state[rd_bank] <= S_EMPTY;
          rd_active      <= 1'b0;
          rd_bank        <= ~rd_bank;
          pass_cnt       <= '0;
        end else begin
          pass_cnt      <= pass_cnt + 1'b1;
          enable_matmul <= 1'b1;
        end
      end
    end
  end

`ifdef PP_SCHED_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (in_valid && !in_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pp_bank_scheduler.sv
module tb_pp_bank_scheduler;

  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          wr_en;
  logic          wr_bank;
  logic [AW-1:0] wr_addr;
  logic          acc_done = 1'b0;
  logic          rd_bank;
  logic          rd_active;
  logic          enable_matmul;
  logic [1:0]    bank_full;
`ifdef PP_SCHED_PERF_EN
  logic [15:0]   stall_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int pulses;
  logic [AW:0] sb [$];
  logic [AW:0] exp_beat;

  always #5 clk = ~clk;

  pp_bank_scheduler #(.ADDR_WIDTH(AW), .DEPTH(4), .RD_PASSES(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr), .acc_done(acc_done),
    .rd_bank(rd_bank), .rd_active(rd_active), .enable_matmul(enable_matmul),
`ifdef PP_SCHED_PERF_EN
    .stall_cnt(stall_cnt),
`endif
    .bank_full(bank_full)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Scoreboard: every accepted beat must match the next expected {bank, addr}.
  always @(negedge clk) begin
    if (rst_n && wr_en) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_beat", 32'd1, 32'd0);
      end else begin
        exp_beat = sb.pop_front();
        check("sb_beat", {27'd0, wr_bank, wr_addr}, {27'd0, exp_beat});
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_bank(input logic bank);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      sb.push_back({bank, AW'(i)});
      @(negedge clk);
      check("fill_wr_en", {31'd0, wr_en}, 32'd1);
      check("fill_wr_addr", {28'd0, wr_addr}, i);
      next_cycle();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    // Reset
    #12 rst_n = 1'b1;
    next_cycle();
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_wr_bank", {31'd0, wr_bank}, 32'd0);
    check("rst_wr_addr", {28'd0, wr_addr}, 32'd0);
    check("rst_rd_active", {31'd0, rd_active}, 32'd0);
    check("rst_bank_full", {30'd0, bank_full}, 32'd0);
    check("rst_enable", {31'd0, enable_matmul}, 32'd0);

    // An acc_done edge while the reader is idle is ignored
    acc_done = 1'b1;
    next_cycle();
    acc_done = 1'b0;
    next_cycle();
    check("idle_acc_rd_active", {31'd0, rd_active}, 32'd0);
    check("idle_acc_enable", {31'd0, enable_matmul}, 32'd0);

    // Fill bank 0
    fill_bank(1'b0);
    @(negedge clk);
    check("fill_bank_full", {30'd0, bank_full}, 32'd1);
    check("fill_wr_bank", {31'd0, wr_bank}, 32'd1);
    check("fill_enable_early", {31'd0, enable_matmul}, 32'd0);
    next_cycle();
    @(negedge clk);
    check("start_enable", {31'd0, enable_matmul}, 32'd1);
    check("start_rd_active", {31'd0, rd_active}, 32'd1);
    check("start_rd_bank", {31'd0, rd_bank}, 32'd0);
    next_cycle();

    // Fill bank 1, which applies backpressure because bank 0 is being read
    fill_bank(1'b1);
    @(negedge clk);
    check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    check("bp_bank_full", {30'd0, bank_full}, 32'd3);
    check("bp_wr_bank", {31'd0, wr_bank}, 32'd0);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_ignored_wr_en", {31'd0, wr_en}, 32'd0);
      check("bp_wr_addr", {28'd0, wr_addr}, 32'd0);
      next_cycle();
    end
    in_valid = 1'b0;
`ifdef PP_SCHED_PERF_EN
    @(negedge clk);
    check("stall_cnt", {16'd0, stall_cnt}, 32'd3);
`endif

    // Hold acc_done high for 5 cycles: this counts as one pass and gives one re-pulse
    pulses = 0;
    acc_done = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (enable_matmul) pulses++;
      next_cycle();
    end
    check("level_pulses", pulses, 32'd1);
    check("level_rd_active", {31'd0, rd_active}, 32'd1);
    check("level_rd_bank", {31'd0, rd_bank}, 32'd0);
    acc_done = 1'b0;
    next_cycle();
    acc_done = 1'b1;
    next_cycle();
    acc_done = 1'b0;
    @(negedge clk);
    check("rel_bank_full", {30'd0, bank_full}, 32'd2);
    check("rel_in_ready", {31'd0, in_ready}, 32'd1);
    check("rel_rd_bank", {31'd0, rd_bank}, 32'd1);
    check("rel_rd_active", {31'd0, rd_active}, 32'd0);
    next_cycle();
    @(negedge clk);
    check("b1_enable", {31'd0, enable_matmul}, 32'd1);
    check("b1_rd_active", {31'd0, rd_active}, 32'd1);
    next_cycle();

    // Two beats into bank 0, then an asynchronous reset in the middle of the cycle
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      sb.push_back({1'b0, AW'(i)});
      next_cycle();
    end
    in_valid = 1'b0;
    check("pre_rst_wr_addr", {28'd0, wr_addr}, 32'd2);
    #1 rst_n = 1'b0;
    #1;
    check("arst_in_ready", {31'd0, in_ready}, 32'd1);
    check("arst_wr_bank", {31'd0, wr_bank}, 32'd0);
    check("arst_wr_addr", {28'd0, wr_addr}, 32'd0);
    check("arst_rd_bank", {31'd0, rd_bank}, 32'd0);
    check("arst_rd_active", {31'd0, rd_active}, 32'd0);
    check("arst_bank_full", {30'd0, bank_full}, 32'd0);
    check("arst_enable", {31'd0, enable_matmul}, 32'd0);
`ifdef PP_SCHED_PERF_EN
    check("arst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
`endif
    next_cycle();
    rst_n = 1'b1;
    next_cycle();

    // The partial fill was discarded, so a fresh fill starts again at address 0
    fill_bank(1'b0);
    @(negedge clk);
    check("refill_bank_full", {30'd0, bank_full}, 32'd1);
    check("sb_drained", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
